rs_age_multi: RTL and testbench
===============================

Name: rs_age_multi

Overview:
- Next-generation reservation station; sits between dispatch/rename and the functional units.
- Holds up to SIZE renamed instructions and wakes operands from C_WIDTH completion tag broadcasts, including a same-cycle bypass.
- Issues per FU class, NUM_CLASS ports, one instruction per class per cycle, always oldest first relative to the ROB head.
- Squashes entries younger than a rewind point on branch recovery.

Parameters:
- D_WIDTH, 3, dispatch lanes
- C_WIDTH, 3, completion broadcast lanes
- NUM_CLASS, 2, FU classes (one issue port each)
- SIZE, 16, entries
- ROB_SIZE, 32, ROB depth (power of two)
- TAG_W, 6, physical register tag width
- Derived: CLS_W=$clog2(NUM_CLASS), ROB_W=$clog2(ROB_SIZE), DS_W=$clog2(D_WIDTH+1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dispatch_valid  in  D_WIDTH  lane valid
- dispatch_class  in  D_WIDTH*CLS_W  FU class
- dispatch_ps0, dispatch_ps1  in  D_WIDTH*TAG_W  source tags
- dispatch_ready  in  D_WIDTH*2  source ready bits, bit0=ps0
- dispatch_pd  in  D_WIDTH*TAG_W  destination tag
- dispatch_rob_idx  in  D_WIDTH*ROB_W  ROB index
- dispatch_empty_slots  out  DS_W  min(free entries, D_WIDTH)
- complete_valid  in  C_WIDTH  broadcast valid
- complete_tag  in  C_WIDTH*TAG_W  broadcast tags
- rob_head  in  ROB_W  oldest ROB index, used for age
- fu_ready  in  NUM_CLASS  class FU accepts this cycle
- issue_valid  out  NUM_CLASS  issue port valid
- issue_pd, issue_ps0, issue_ps1  out  NUM_CLASS*TAG_W  issued tags
- issue_rob_idx  out  NUM_CLASS*ROB_W  issued ROB index
- rewind_valid  in  1  recovery request
- rewind_rob_index  in  ROB_W  rewind point (oldest surviving instruction)

Behaviour:
- Reset (async): all entries invalid; occupancy 0; dispatch_empty_slots=min(SIZE,D_WIDTH); all issue_* outputs 0.
- Entry fields: valid, class, ps0/ps1, rdy0/rdy1, pd, rob_idx.
- Age of an entry = (rob_idx - rob_head) mod ROB_SIZE; smaller age is older.
- Dispatch:
  - Lane k is written at posedge if dispatch_valid[k] and k < dispatch_empty_slots. Lanes at or above that count are dropped silently.
  - Lanes fill the lowest-index free entries in lane order.
  - A source's ready bit is set if dispatch_ready is set or its tag matches any valid complete_tag in the same cycle.
  - A dispatched entry cannot issue in its dispatch cycle; earliest issue is the next cycle.
- dispatch_empty_slots is combinational from registered occupancy only. It does not credit same-cycle issue.
- Wakeup: at posedge, any stored source whose tag equals a valid complete_tag sets its ready bit.
- Bypass: issue eligibility uses (rdyX OR tag matches a current valid complete_tag). An entry can therefore issue in the same cycle its last operand completes.
- Selection, per class c, combinational:
  - Pick the oldest valid eligible entry of class c.
  - Ties are impossible (unique rob_idx); if they occur, pick the lower entry index.
  - issue_valid[c] = a candidate exists AND fu_ready[c] AND !rewind_valid.
  - When issue_valid[c]=0, that port's issue fields are driven to 0.
- Deallocation: an entry issued on port c is invalidated at the same posedge. A slot freed this cycle is reusable only from the next cycle.
- Rewind:
  - When rewind_valid=1, at posedge invalidate every entry with age > (rewind_rob_index - rob_head) mod ROB_SIZE.
  - All dispatch lanes are ignored that cycle; all issue_valid are 0.
  - Wakeup of surviving entries still applies.
- Simultaneous dispatch + issue + complete in one cycle are all honoured. Occupancy next = occ + accepted dispatches - issues (or minus squashed entries on rewind).
- Occupancy never exceeds SIZE. Full gives dispatch_empty_slots=0; empty gives all issue_valid=0.
- Reset asserted mid-operation clears everything immediately, independent of clock.

Test Plan:
- Reset, then dispatch one ready class-0 instruction (pd=0x40, rob 0) -> next cycle issue_valid[0]=1, issue_pd[0]=0x40; entry freed; empty_slots=3.
- Dispatch 3 not-ready class-0 instructions waiting on 0x41, rob 5/3/4, rob_head=0; complete 0x41 next cycle -> same-cycle bypass issue of rob 3, then rob 4, then rob 5 on successive cycles.
- Class isolation: ready class-0 and class-1 entries, fu_ready=2'b10 -> only port 1 issues; port 0 issues once fu_ready[0]=1.
- Fill 16 not-ready entries, 3 per cycle -> empty_slots reads 3,3,3,3,3,1,0; extra valid lanes dropped; occupancy stays 16.
- Wrap-around age: rob_head=30, ready entries rob 1 and rob 31 -> rob 31 issues first.
- Rewind: entries rob 2..9, rob_head=2, rewind_rob_index=5 with dispatch asserted -> rob 6..9 squashed, dispatch dropped, issue_valid=0 that cycle; empty_slots=min(12,3)=3 next cycle.

Source files
------------

// File: rtl/rs_age_multi.sv
// rtl/rs_age_multi.sv - age-ordered multi-class reservation station with wakeup, bypass and rewind
module rs_age_multi #(
    parameter int D_WIDTH   = 3,
    parameter int C_WIDTH   = 3,
    parameter int NUM_CLASS = 2,
    parameter int SIZE      = 16,
    parameter int ROB_SIZE  = 32,
    parameter int TAG_W     = 6,
    localparam int CLS_W    = $clog2(NUM_CLASS),
    localparam int ROB_W    = $clog2(ROB_SIZE),
    localparam int DS_W     = $clog2(D_WIDTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [D_WIDTH-1:0]         dispatch_valid,
    input  logic [D_WIDTH*CLS_W-1:0]   dispatch_class,
    input  logic [D_WIDTH*TAG_W-1:0]   dispatch_ps0,
    input  logic [D_WIDTH*TAG_W-1:0]   dispatch_ps1,
    input  logic [D_WIDTH*2-1:0]       dispatch_ready,
    input  logic [D_WIDTH*TAG_W-1:0]   dispatch_pd,
    input  logic [D_WIDTH*ROB_W-1:0]   dispatch_rob_idx,
    output logic [DS_W-1:0]            dispatch_empty_slots,
    input  logic [C_WIDTH-1:0]         complete_valid,
    input  logic [C_WIDTH*TAG_W-1:0]   complete_tag,
    input  logic [ROB_W-1:0]           rob_head,
    input  logic [NUM_CLASS-1:0]       fu_ready,
    output logic [NUM_CLASS-1:0]       issue_valid,
    output logic [NUM_CLASS*TAG_W-1:0] issue_pd,
    output logic [NUM_CLASS*TAG_W-1:0] issue_ps0,
    output logic [NUM_CLASS*TAG_W-1:0] issue_ps1,
    output logic [NUM_CLASS*ROB_W-1:0] issue_rob_idx,
    input  logic                       rewind_valid,
    input  logic [ROB_W-1:0]           rewind_rob_index
);

    localparam int OCC_W = $clog2(SIZE + 1);
    localparam int IDX_W = $clog2(SIZE);

    logic [SIZE-1:0]  ent_valid, ent_rdy0, ent_rdy1;
    logic [CLS_W-1:0] ent_cls [SIZE];
    logic [TAG_W-1:0] ent_ps0 [SIZE];
    logic [TAG_W-1:0] ent_ps1 [SIZE];
    logic [TAG_W-1:0] ent_pd  [SIZE];
    logic [ROB_W-1:0] ent_rob [SIZE];
    logic [ROB_W-1:0] ent_age [SIZE];

    logic [SIZE-1:0]      hit0, hit1, eligible, issue_clr;
    logic [D_WIDTH-1:0]   lane_take, lane_hit0, lane_hit1;
    logic [IDX_W-1:0]     lane_idx [D_WIDTH];
    logic [NUM_CLASS-1:0] sel_found;
    logic [IDX_W-1:0]     sel_idx  [NUM_CLASS];
    logic [OCC_W-1:0]     occ, free_cnt;
    logic [ROB_W-1:0]     rewind_age;

    function automatic logic tag_hit(input logic [TAG_W-1:0] t,
                                     input logic [C_WIDTH-1:0] cv,
                                     input logic [C_WIDTH*TAG_W-1:0] ct);
        logic h;
        h = 1'b0;
        for (int j = 0; j < C_WIDTH; j++)
            if (cv[j] && ct[j*TAG_W +: TAG_W] == t) h = 1'b1;
        return h;
    endfunction

    // Bypass-aware operand readiness and age relative to the ROB head
    always_comb begin
        rewind_age = rewind_rob_index - rob_head;
        for (int i = 0; i < SIZE; i++) begin
            hit0[i]     = tag_hit(ent_ps0[i], complete_valid, complete_tag);
            hit1[i]     = tag_hit(ent_ps1[i], complete_valid, complete_tag);
            eligible[i] = ent_valid[i] & (ent_rdy0[i] | hit0[i]) & (ent_rdy1[i] | hit1[i]);
            ent_age[i]  = ent_rob[i] - rob_head;
        end
    end

    // Free-slot credit from registered occupancy only
    always_comb begin
        occ = '0;
        for (int i = 0; i < SIZE; i++) occ = occ + OCC_W'(ent_valid[i]);
        free_cnt = OCC_W'(SIZE) - occ;
        dispatch_empty_slots = (free_cnt >= OCC_W'(D_WIDTH)) ? DS_W'(D_WIDTH) : DS_W'(free_cnt);
    end

    // Oldest eligible entry per class; strict compare keeps the lower index on a tie
    always_comb begin
        logic [ROB_W-1:0] best_age;
        for (int c = 0; c < NUM_CLASS; c++) begin
            sel_found[c] = 1'b0;
            sel_idx[c]   = '0;
            best_age     = '1;
            for (int i = 0; i < SIZE; i++) begin
                if (eligible[i] && ent_cls[i] == CLS_W'(c) &&
                    (!sel_found[c] || ent_age[i] < best_age)) begin
                    sel_found[c] = 1'b1;
                    sel_idx[c]   = IDX_W'(i);
                    best_age     = ent_age[i];
                end
            end
        end
    end

    // Issue ports, zeroed when idle, and the matching deallocation mask
    always_comb begin
        issue_clr = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            issue_valid[c] = sel_found[c] & fu_ready[c] & ~rewind_valid;
            issue_pd[c*TAG_W +: TAG_W]      = issue_valid[c] ? ent_pd[sel_idx[c]]  : '0;
            issue_ps0[c*TAG_W +: TAG_W]     = issue_valid[c] ? ent_ps0[sel_idx[c]] : '0;
            issue_ps1[c*TAG_W +: TAG_W]     = issue_valid[c] ? ent_ps1[sel_idx[c]] : '0;
            issue_rob_idx[c*ROB_W +: ROB_W] = issue_valid[c] ? ent_rob[sel_idx[c]] : '0;
            if (issue_valid[c]) issue_clr[sel_idx[c]] = 1'b1;
        end
    end

    // Lane-ordered allocation into the lowest free entries at the start of the cycle
    always_comb begin
        logic [SIZE-1:0] busy;
        logic            got;
        busy = ent_valid;
        for (int k = 0; k < D_WIDTH; k++) begin
            lane_take[k] = dispatch_valid[k] && (DS_W'(k) < dispatch_empty_slots) && !rewind_valid;
            lane_hit0[k] = tag_hit(dispatch_ps0[k*TAG_W +: TAG_W], complete_valid, complete_tag);
            lane_hit1[k] = tag_hit(dispatch_ps1[k*TAG_W +: TAG_W], complete_valid, complete_tag);
            lane_idx[k]  = '0;
            got          = 1'b0;
            if (lane_take[k]) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (!got && !busy[i]) begin
                        lane_idx[k] = IDX_W'(i);
                        got         = 1'b1;
                    end
                end
                busy[lane_idx[k]] = 1'b1;
            end
        end
    end

    // Entry state: wakeup, issue/rewind invalidation, then dispatch writes into free slots
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_rdy0  <= '0;
            ent_rdy1  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                ent_cls[i] <= '0;
                ent_ps0[i] <= '0;
                ent_ps1[i] <= '0;
                ent_pd[i]  <= '0;
                ent_rob[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                ent_rdy0[i] <= ent_rdy0[i] | hit0[i];
                ent_rdy1[i] <= ent_rdy1[i] | hit1[i];
                if (rewind_valid) begin
                    if (ent_age[i] > rewind_age) ent_valid[i] <= 1'b0;
                end else if (issue_clr[i]) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            for (int k = 0; k < D_WIDTH; k++) begin
                if (lane_take[k]) begin
                    ent_valid[lane_idx[k]] <= 1'b1;
                    ent_cls[lane_idx[k]]   <= dispatch_class[k*CLS_W +: CLS_W];
                    ent_ps0[lane_idx[k]]   <= dispatch_ps0[k*TAG_W +: TAG_W];
                    ent_ps1[lane_idx[k]]   <= dispatch_ps1[k*TAG_W +: TAG_W];
                    ent_pd[lane_idx[k]]    <= dispatch_pd[k*TAG_W +: TAG_W];
                    ent_rob[lane_idx[k]]   <= dispatch_rob_idx[k*ROB_W +: ROB_W];
                    ent_rdy0[lane_idx[k]]  <= dispatch_ready[2*k]     | lane_hit0[k];
                    ent_rdy1[lane_idx[k]]  <= dispatch_ready[2*k + 1] | lane_hit1[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age_multi.sv
// tb/tb_rs_age_multi.sv - self-checking bench for rs_age_multi against a pool-based reference model
module tb_rs_age_multi;

    localparam int D   = 3;
    localparam int C   = 3;
    localparam int NC  = 2;
    localparam int SZ  = 16;
    localparam int RS  = 32;
    localparam int TW  = 7;   // tags up to 0x41 need 7 bits
    localparam int RW  = 5;
    localparam int DSW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [D-1:0]      d_valid;
    logic [D-1:0]      d_class;
    logic [D*TW-1:0]   d_ps0, d_ps1, d_pd;
    logic [2*D-1:0]    d_ready;
    logic [D*RW-1:0]   d_rob;
    logic [DSW-1:0]    empty_slots;
    logic [C-1:0]      c_valid;
    logic [C*TW-1:0]   c_tag;
    logic [RW-1:0]     rob_head;
    logic [NC-1:0]     fu_ready;
    logic [NC-1:0]     issue_valid;
    logic [NC*TW-1:0]  issue_pd, issue_ps0, issue_ps1;
    logic [NC*RW-1:0]  issue_rob;
    logic              rewind_valid;
    logic [RW-1:0]     rewind_idx;

    rs_age_multi #(.TAG_W(TW)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(d_valid), .dispatch_class(d_class),
        .dispatch_ps0(d_ps0), .dispatch_ps1(d_ps1), .dispatch_ready(d_ready),
        .dispatch_pd(d_pd), .dispatch_rob_idx(d_rob),
        .dispatch_empty_slots(empty_slots),
        .complete_valid(c_valid), .complete_tag(c_tag),
        .rob_head(rob_head), .fu_ready(fu_ready),
        .issue_valid(issue_valid), .issue_pd(issue_pd),
        .issue_ps0(issue_ps0), .issue_ps1(issue_ps1), .issue_rob_idx(issue_rob),
        .rewind_valid(rewind_valid), .rewind_rob_index(rewind_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cls;
        int ps0;
        int ps1;
        bit r0;
        bit r1;
        int pd;
        int rob;
    } ent_t;

    ent_t pool[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_es;
    bit   exp_iv   [NC];
    int   exp_pick [NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input int t);
        for (int j = 0; j < C; j++)
            if (c_valid[j] && int'(c_tag[j*TW +: TW]) == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int age(input int rob);
        return (rob - int'(rob_head)) & (RS - 1);
    endfunction

    function automatic bit rob_used(input int r, input int k);
        foreach (pool[i]) if (pool[i].rob == r) return 1'b1;
        for (int j = 0; j < k; j++) if (int'(d_rob[j*RW +: RW]) == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        int best;
        exp_es = (SZ - pool.size()) < D ? SZ - pool.size() : D;
        for (int c = 0; c < NC; c++) begin
            exp_pick[c] = -1;
            best = RS;
            foreach (pool[i]) begin
                if (pool[i].cls == c && (pool[i].r0 || hit(pool[i].ps0)) &&
                    (pool[i].r1 || hit(pool[i].ps1)) && age(pool[i].rob) < best) begin
                    best = age(pool[i].rob);
                    exp_pick[c] = i;
                end
            end
            exp_iv[c] = exp_pick[c] >= 0 && fu_ready[c] && !rewind_valid;
        end
    endtask

    task automatic model_update();
        int gone[$];
        ent_t e;
        if (rewind_valid) begin
            for (int i = pool.size() - 1; i >= 0; i--)
                if (age(pool[i].rob) > age(int'(rewind_idx))) pool.delete(i);
        end else begin
            for (int c = 0; c < NC; c++) if (exp_iv[c]) gone.push_back(pool[exp_pick[c]].rob);
            foreach (gone[g])
                for (int i = pool.size() - 1; i >= 0; i--)
                    if (pool[i].rob == gone[g]) pool.delete(i);
        end
        foreach (pool[i]) begin
            pool[i].r0 = pool[i].r0 | hit(pool[i].ps0);
            pool[i].r1 = pool[i].r1 | hit(pool[i].ps1);
        end
        if (!rewind_valid) begin
            for (int k = 0; k < D; k++) begin
                if (d_valid[k] && k < exp_es) begin
                    e.cls = int'(d_class[k]);
                    e.ps0 = int'(d_ps0[k*TW +: TW]);
                    e.ps1 = int'(d_ps1[k*TW +: TW]);
                    e.pd  = int'(d_pd[k*TW +: TW]);
                    e.rob = int'(d_rob[k*RW +: RW]);
                    e.r0  = d_ready[2*k] | hit(e.ps0);
                    e.r1  = d_ready[2*k+1] | hit(e.ps1);
                    pool.push_back(e);
                end
            end
        end
    endtask

    // Compare all outputs against the model a little after the inputs settle
    task automatic eval();
        logic [3*TW+RW:0] got, exp;
        #1;
        model_eval();
        check("empty_slots", empty_slots, 64'(exp_es));
        for (int c = 0; c < NC; c++) begin
            got = {issue_valid[c], issue_pd[c*TW +: TW], issue_ps0[c*TW +: TW],
                   issue_ps1[c*TW +: TW], issue_rob[c*RW +: RW]};
            if (exp_iv[c])
                exp = {1'b1, TW'(pool[exp_pick[c]].pd), TW'(pool[exp_pick[c]].ps0),
                       TW'(pool[exp_pick[c]].ps1), RW'(pool[exp_pick[c]].rob)};
            else
                exp = '0;
            check($sformatf("issue%0d", c), 64'(got), 64'(exp));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle();
        d_valid = '0; d_class = '0; d_ps0 = '0; d_ps1 = '0; d_pd = '0;
        d_ready = '0; d_rob = '0; c_valid = '0; c_tag = '0;
        fu_ready = '0; rewind_valid = 1'b0; rewind_idx = '0;
    endtask

    task automatic set_lane(input int k, input int cls, input int ps0, input int ps1,
                            input int rdy, input int pd, input int rob);
        d_valid[k] = 1'b1;
        d_class[k] = cls[0];
        d_ps0[k*TW +: TW] = TW'(ps0);
        d_ps1[k*TW +: TW] = TW'(ps1);
        d_ready[2*k +: 2] = 2'(rdy);
        d_pd[k*TW +: TW]  = TW'(pd);
        d_rob[k*RW +: RW] = RW'(rob);
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            idle();
            c_valid[0] = 1'b1;
            c_tag[TW-1:0] = 7'h41;
            fu_ready = 2'b11;
            eval();
            tick();
        end
        idle();
    endtask

    int fill_es [7] = '{3, 3, 3, 3, 3, 1, 0};
    int rn;
    int r;

    initial begin
        idle();
        rob_head = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        eval();
        check("rst_es", empty_slots, 3);
        check("rst_iv", issue_valid, 0);

        // single ready class-0 instruction
        set_lane(0, 0, 0, 0, 3, 'h40, 0);
        eval();
        tick();
        idle();
        fu_ready = 2'b11;
        eval();
        check("t1_iv", issue_valid, 2'b01);
        check("t1_pd", issue_pd[TW-1:0], 'h40);
        tick();
        idle();
        eval();
        check("t1_es", empty_slots, 3);

        // bypass wakeup, then age order 3,4,5
        set_lane(0, 0, 'h41, 0, 2, 1, 5);
        set_lane(1, 0, 'h41, 0, 2, 2, 3);
        set_lane(2, 0, 'h41, 0, 2, 3, 4);
        eval();
        tick();
        idle();
        fu_ready = 2'b11;
        c_valid[0] = 1'b1;
        c_tag[TW-1:0] = 7'h41;
        eval();
        check("t2_rob3", {issue_valid[0], issue_rob[RW-1:0]}, {1'b1, 5'd3});
        tick();
        idle();
        fu_ready = 2'b11;
        eval();
        check("t2_rob4", {issue_valid[0], issue_rob[RW-1:0]}, {1'b1, 5'd4});
        tick();
        eval();
        check("t2_rob5", {issue_valid[0], issue_rob[RW-1:0]}, {1'b1, 5'd5});
        tick();

        // class isolation
        idle();
        set_lane(0, 0, 0, 0, 3, 'h10, 10);
        set_lane(1, 1, 0, 0, 3, 'h11, 11);
        eval();
        tick();
        idle();
        fu_ready = 2'b10;
        eval();
        check("t3_only1", issue_valid, 2'b10);
        tick();
        fu_ready = 2'b11;
        eval();
        check("t3_then0", issue_valid, 2'b01);
        tick();

        // fill to capacity with extra lanes dropped
        rn = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            idle();
            for (int k = 0; k < D; k++) begin
                set_lane(k, 0, 'h41, 0, 2, 'h20 + rn, rn);
                rn++;
            end
            eval();
            check($sformatf("t4_es%0d", cyc), empty_slots, 64'(fill_es[cyc]));
            tick();
        end
        idle();
        eval();
        check("t4_full", empty_slots, 0);
        drain();

        // wrap-around age
        rob_head = 5'd30;
        set_lane(0, 0, 0, 0, 3, 'h31, 1);
        set_lane(1, 0, 0, 0, 3, 'h32, 31);
        eval();
        tick();
        idle();
        fu_ready = 2'b01;
        eval();
        check("t5_rob31", issue_rob[RW-1:0], 31);
        tick();
        eval();
        check("t5_rob1", issue_rob[RW-1:0], 1);
        tick();

        // rewind squashes rob 6..9
        rob_head = 5'd2;
        for (int cyc = 0; cyc < 3; cyc++) begin
            idle();
            for (int k = 0; k < D; k++)
                if (2 + cyc*3 + k <= 9) set_lane(k, k % 2, 'h41, 'h41, 0, 'h50 + cyc*3 + k, 2 + cyc*3 + k);
            eval();
            tick();
        end
        idle();
        set_lane(0, 0, 0, 0, 3, 'h60, 20);
        set_lane(1, 1, 0, 0, 3, 'h61, 21);
        fu_ready = 2'b11;
        rewind_valid = 1'b1;
        rewind_idx = 5'd5;
        eval();
        check("t6_iv", issue_valid, 0);
        tick();
        idle();
        eval();
        check("t6_es", empty_slots, 3);
        drain();

        // randomized traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle();
            if (cyc % 8 == 0) rob_head = RW'($urandom_range(0, RS-1));
            for (int k = 0; k < D; k++) begin
                do r = $urandom_range(0, RS-1); while (rob_used(r, k));
                d_rob[k*RW +: RW] = RW'(r);
                if ($urandom_range(0, 1) == 1)
                    set_lane(k, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 3), $urandom_range(0, 127), r);
            end
            for (int j = 0; j < C; j++) begin
                c_valid[j] = 1'($urandom_range(0, 1));
                c_tag[j*TW +: TW] = TW'($urandom_range(0, 15));
            end
            fu_ready = NC'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                rewind_valid = 1'b1;
                rewind_idx = RW'($urandom_range(0, RS-1));
            end
            eval();
            tick();
        end

        // asynchronous reset mid-cycle
        idle();
        #2;
        reset = 1'b1;
        #1;
        pool.delete();
        check("async_es", empty_slots, 3);
        check("async_iv", issue_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        eval();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
